// File: rtl/multicore_pio_pkg.sv
// Shared constants for the multi-channel PIO bank: register offsets, edge-capture
// modes and the Avalon address width helper.
package multicore_pio_pkg;

  localparam logic [2:0] REG_DATA     = 3'd0;
  localparam logic [2:0] REG_DIR      = 3'd1;
  localparam logic [2:0] REG_MASK     = 3'd2;
  localparam logic [2:0] REG_EDGE_CAP = 3'd3;
  localparam logic [2:0] REG_OUTSET   = 3'd4;
  localparam logic [2:0] REG_OUTCLR   = 3'd5;
  localparam logic [2:0] REG_MODE     = 3'd6;
  localparam logic [2:0] REG_RSVD     = 3'd7;

  localparam logic [1:0] EDGE_RISE = 2'd0;
  localparam logic [1:0] EDGE_FALL = 2'd1;
  localparam logic [1:0] EDGE_BOTH = 2'd2;
  localparam logic [1:0] EDGE_OFF  = 2'd3;

  // Address is {channel, reg[2:0]}.
  function automatic int pio_addr_w(input int num_ch);
    return $clog2(num_ch) + 3;
  endfunction

endpackage

// File: rtl/multicore_sync2.sv
// Two-flop synchroniser for asynchronous pin inputs, any width.
module multicore_sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/multicore_pio_bank.sv
// Avalon-MM GPIO bank: NUM_CH channels of DATA_W bits with per-bit direction,
// synchronised inputs, per-channel edge capture and a masked registered irq.
module multicore_pio_bank
  import multicore_pio_pkg::*;
#(
  parameter int              NUM_CH    = 4,
  parameter int              DATA_W    = 8,
  parameter logic [DATA_W-1:0] OUT_RESET = '0,
  localparam int             AW        = pio_addr_w(NUM_CH),
  localparam int             PW        = NUM_CH * DATA_W
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic [AW-1:0] avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  output logic [31:0]   avs_readdata,
  output logic          avs_readdatavalid,
  input  logic [PW-1:0] pio_in,
  output logic [PW-1:0] pio_out,
  output logic [PW-1:0] pio_oe,
  output logic          irq
);

  // Bus protocol: no waitrequest. avs_read sampled at edge N produces
  // avs_readdatavalid + data for exactly the cycle after N (pre-write values);
  // avs_write commits at the edge that samples it.
  logic [AW-1:0]     ch_idx;
  logic [2:0]        reg_sel;
  logic [DATA_W-1:0] wdata;
  logic              unused_wdata;

  assign ch_idx       = avs_address >> 3;
  assign reg_sel      = avs_address[2:0];
  assign wdata        = avs_writedata[DATA_W-1:0];
  assign unused_wdata = ^avs_writedata;

  logic [PW-1:0] sync_in;
  logic [PW-1:0] prev_q;

  multicore_sync2 #(.W(PW)) u_sync (
    .clk_i (clk_clk),
    .rst_ni(reset_reset_n),
    .d_i   (pio_in),
    .q_o   (sync_in)
  );

  logic [NUM_CH-1:0][DATA_W-1:0] out_w, dir_w, mask_w, cap_w;
  logic [NUM_CH-1:0][1:0]        mode_w;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [AW-1:0] CH_ID = AW'(c);

    logic [DATA_W-1:0] out_q, out_d, dir_q, dir_d, mask_q, mask_d, cap_q, cap_d;
    logic [DATA_W-1:0] edge_set, s_c, p_c;
    logic [1:0]        mode_q, mode_d;
    logic              wr_hit;

    assign s_c    = sync_in[c*DATA_W +: DATA_W];
    assign p_c    = prev_q[c*DATA_W +: DATA_W];
    assign wr_hit = avs_write && (ch_idx == CH_ID);

    always_comb begin
      edge_set = '0;
      case (mode_q)
        EDGE_RISE: edge_set = s_c & ~p_c;
        EDGE_FALL: edge_set = ~s_c & p_c;
        EDGE_BOTH: edge_set = s_c ^ p_c;
        EDGE_OFF:  edge_set = '0;
        default:   edge_set = '0;
      endcase
    end

    always_comb begin
      out_d  = out_q;
      dir_d  = dir_q;
      mask_d = mask_q;
      cap_d  = cap_q;
      mode_d = mode_q;
      if (wr_hit) begin
        case (reg_sel)
          REG_DATA:     out_d  = wdata;
          REG_DIR:      dir_d  = wdata;
          REG_MASK:     mask_d = wdata;
          REG_EDGE_CAP: cap_d  = cap_q & ~wdata;
          REG_OUTSET:   out_d  = out_q | wdata;
          REG_OUTCLR:   out_d  = out_q & ~wdata;
          REG_MODE:     mode_d = avs_writedata[1:0];
          REG_RSVD:     ;
          default:      ;
        endcase
      end
      // A fresh edge beats a simultaneous write-1-to-clear.
      cap_d = cap_d | edge_set;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        out_q  <= OUT_RESET;
        dir_q  <= '0;
        mask_q <= '0;
        cap_q  <= '0;
        mode_q <= EDGE_RISE;
      end else begin
        out_q  <= out_d;
        dir_q  <= dir_d;
        mask_q <= mask_d;
        cap_q  <= cap_d;
        mode_q <= mode_d;
      end
    end

    assign out_w[c]  = out_q;
    assign dir_w[c]  = dir_q;
    assign mask_w[c] = mask_q;
    assign cap_w[c]  = cap_q;
    assign mode_w[c] = mode_q;
  end

  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_idx == AW'(c)) begin
        case (reg_sel)
          REG_DATA:     rd_val = 32'((dir_w[c] & out_w[c]) |
                                     (~dir_w[c] & sync_in[c*DATA_W +: DATA_W]));
          REG_DIR:      rd_val = 32'(dir_w[c]);
          REG_MASK:     rd_val = 32'(mask_w[c]);
          REG_EDGE_CAP: rd_val = 32'(cap_w[c]);
          REG_MODE:     rd_val = 32'(mode_w[c]);
          default:      rd_val = '0;
        endcase
      end
    end
  end

  logic [31:0] rdata_q;
  logic        rvalid_q;
  logic        irq_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
      prev_q   <= '0;
    end else begin
      rdata_q  <= avs_read ? rd_val : '0;
      rvalid_q <= avs_read;
      irq_q    <= |(cap_w & mask_w);
      prev_q   <= sync_in;
    end
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign irq               = irq_q;
  assign pio_out           = out_w;
  assign pio_oe            = dir_w;

endmodule

// File: tb/tb_multicore_pio_bank.sv
// Self-checking bench for multicore_pio_bank: register vectors, edge capture and
// irq timing, out-of-range channels (3-channel instance) and reset during a read.
module tb_multicore_pio_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  address;
  logic        rd_en, wr_en;
  logic [31:0] wdata;
  logic [31:0] pio_in;

  logic [31:0] rdata, pio_out, pio_oe;
  logic        rvalid, irq;
  logic [31:0] s_rdata;
  logic        s_rvalid, s_irq;
  logic [23:0] s_pio_out, s_pio_oe;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  multicore_pio_bank #(.NUM_CH(4), .DATA_W(8), .OUT_RESET(8'hA5)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(address),
    .avs_read(rd_en), .avs_write(wr_en), .avs_writedata(wdata),
    .avs_readdata(rdata), .avs_readdatavalid(rvalid),
    .pio_in(pio_in), .pio_out(pio_out), .pio_oe(pio_oe), .irq(irq)
  );

  // Three channels share the bus so channel 3 is an out-of-range address.
  multicore_pio_bank #(.NUM_CH(3), .DATA_W(8), .OUT_RESET(8'h00)) dut_s (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(address),
    .avs_read(rd_en), .avs_write(wr_en), .avs_writedata(wdata),
    .avs_readdata(s_rdata), .avs_readdatavalid(s_rvalid),
    .pio_in(pio_in[23:0]), .pio_out(s_pio_out), .pio_oe(s_pio_oe), .irq(s_irq)
  );

  function automatic logic [4:0] ra(input int ch, input int r);
    return 5'(ch * 8 + r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; rd_en = 1'b0; address = a; wdata = d;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e);
    rd_en = 1'b1; wr_en = 1'b0; address = a;
    exp_q.push_back(e);
    step(1);
    rd_en = 1'b0;
  endtask

  task automatic monitor();
    logic seen;
    forever begin
      @(posedge clk);
      seen = rd_en && rst_n;
      @(negedge clk);
      if (rst_n) begin
        if (seen || rvalid) check("rvalid_latency", 32'(rvalid), 32'(seen));
        if (rvalid) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rdata_unexpected: got %h with no read outstanding", rdata);
          end else begin
            check("rdata", rdata, exp_q.pop_front());
          end
        end
      end
    end
  endtask

  initial begin
    rd_en = 1'b0; wr_en = 1'b0; address = '0; wdata = '0; pio_in = '0;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pio_out", pio_out, 32'hA5A5A5A5);
    check("rst_pio_oe", pio_oe, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_s_pio_out", 32'(s_pio_out), 32'h0);
    rst_n = 1'b1;
    step(1);
    pio_in[15:8] = 8'h0F;

    vecs.push_back('{1'b0, ra(2,6), 32'h0, 32'h0});
    vecs.push_back('{1'b0, ra(0,1), 32'h0, 32'h0});
    vecs.push_back('{1'b0, ra(0,0), 32'h0, 32'h0});
    vecs.push_back('{1'b0, ra(0,3), 32'h0, 32'h0});
    vecs.push_back('{1'b1, ra(1,1), 32'hF0, 32'h0});
    vecs.push_back('{1'b1, ra(1,0), 32'h3C, 32'h0});
    vecs.push_back('{1'b0, ra(1,0), 32'h0, 32'h3F});
    vecs.push_back('{1'b0, ra(1,1), 32'h0, 32'hF0});
    vecs.push_back('{1'b0, ra(1,3), 32'h0, 32'h0F});
    vecs.push_back('{1'b1, ra(1,3), 32'h03, 32'h0});
    vecs.push_back('{1'b0, ra(1,3), 32'h0, 32'h0C});
    vecs.push_back('{1'b1, ra(1,4), 32'h01, 32'h0});
    vecs.push_back('{1'b1, ra(1,5), 32'h30, 32'h0});
    vecs.push_back('{1'b0, ra(1,4), 32'h0, 32'h0});
    vecs.push_back('{1'b0, ra(1,5), 32'h0, 32'h0});
    vecs.push_back('{1'b0, ra(1,0), 32'h0, 32'h0F});
    vecs.push_back('{1'b1, ra(1,1), 32'hFF, 32'h0});
    vecs.push_back('{1'b0, ra(1,0), 32'h0, 32'h0D});
    vecs.push_back('{1'b1, ra(2,1), 32'hFF, 32'h0});
    vecs.push_back('{1'b1, ra(2,0), 32'hFFFFFF5A, 32'h0});
    vecs.push_back('{1'b0, ra(2,0), 32'h0, 32'h5A});
    vecs.push_back('{1'b1, ra(2,6), 32'hFFFFFFFE, 32'h0});
    vecs.push_back('{1'b0, ra(2,6), 32'h0, 32'h2});
    vecs.push_back('{1'b1, ra(2,2), 32'h81, 32'h0});
    vecs.push_back('{1'b0, ra(2,2), 32'h0, 32'h81});
    vecs.push_back('{1'b0, ra(1,7), 32'h0, 32'h0});
    vecs.push_back('{1'b1, ra(1,7), 32'hFF, 32'h0});
    vecs.push_back('{1'b0, ra(1,0), 32'h0, 32'h0D});
    vecs.push_back('{1'b0, ra(1,2), 32'h0, 32'h0});

    foreach (vecs[i]) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
      else            rd(vecs[i].addr, vecs[i].exp);
    end

    // Read and write to the same register in one cycle: read sees the old value.
    rd_en = 1'b1; wr_en = 1'b1; address = ra(1,0); wdata = 32'h77;
    exp_q.push_back(32'h0D);
    step(1);
    rd_en = 1'b0; wr_en = 1'b0;
    rd(ra(1,0), 32'h77);
    check("pio_out_mix", pio_out, 32'hA55A77A5);
    check("pio_oe_mix", pio_oe, 32'h00FFFF00);

    // Rising capture on ch0 bit0, irq timing and clear.
    wr(ra(0,2), 32'h01);
    check("irq_idle", 32'(irq), 32'h0);
    pio_in[0] = 1'b1;
    step(3);
    check("irq_t3", 32'(irq), 32'h0);
    step(1);
    check("irq_t4", 32'(irq), 32'h1);
    rd(ra(0,3), 32'h01);
    wr(ra(0,3), 32'h01);
    check("irq_hold_after_w1c", 32'(irq), 32'h1);
    step(1);
    check("irq_cleared", 32'(irq), 32'h0);

    // Falling-only capture on ch3 bit7, then capture disabled.
    wr(ra(3,6), 32'h1);
    pio_in[31] = 1'b1;
    step(4);
    rd(ra(3,3), 32'h00);
    pio_in[31] = 1'b0;
    step(4);
    rd(ra(3,3), 32'h80);
    wr(ra(3,3), 32'h80);
    wr(ra(3,6), 32'h3);
    rd(ra(3,6), 32'h3);
    pio_in[31] = 1'b1;
    step(4);
    rd(ra(3,3), 32'h00);
    pio_in[31] = 1'b0;
    step(4);
    rd(ra(3,3), 32'h00);

    // Capture set and W1C on the same bit in the same cycle.
    pio_in[0] = 1'b0;
    step(4);
    pio_in[0] = 1'b1;
    step(5);
    check("irq_rearm", 32'(irq), 32'h1);
    pio_in[0] = 1'b0;
    step(4);
    pio_in[0] = 1'b1;
    step(2);
    wr(ra(0,3), 32'h01);
    check("irq_setwins_a", 32'(irq), 32'h1);
    step(1);
    check("irq_setwins_b", 32'(irq), 32'h1);
    rd(ra(0,3), 32'h01);

    // Out-of-range channel on the 3-channel instance.
    rd(ra(3,0), 32'h0);
    check("oor_valid_a", 32'(s_rvalid), 32'h1);
    check("oor_rdata_a", s_rdata, 32'h0);
    rd(ra(3,6), 32'h3);
    check("oor_valid_b", 32'(s_rvalid), 32'h1);
    check("oor_rdata_b", s_rdata, 32'h0);
    wr(ra(3,0), 32'hFF);
    wr(ra(3,1), 32'hFF);
    wr(ra(3,4), 32'hFF);
    check("oor_s_pio_out", 32'(s_pio_out), 32'h005A7700);
    check("oor_s_pio_oe", 32'(s_pio_oe), 32'h00FFFF00);

    // Reset between a read and its response.
    rd_en = 1'b1; address = ra(0,1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    check("rst_drop_valid", 32'(rvalid), 32'h0);
    check("rst2_pio_out", pio_out, 32'hA5A5A5A5);
    check("rst2_irq", 32'(irq), 32'h0);
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    check("rst_no_late_valid", 32'(rvalid), 32'h0);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
